// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key-event receiver and its event FIFO.
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned EVENT_W    = 10;
  localparam logic [7:0]  CODE_EXT   = 8'hE0;
  localparam logic [7:0]  CODE_BRK   = 8'hF0;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // start low, stop high, odd parity across data+parity bits
  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
    return !f[0] && f[10] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO; head reads zero while empty.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned LOG2 = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [EVENT_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [LOG2:0]      count,
  output logic [EVENT_W-1:0] head
);

  localparam int unsigned DEPTH = 1 << LOG2;

  logic [EVENT_W-1:0] mem_q [DEPTH];
  logic [LOG2-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LOG2-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LOG2:0]      count_q, count_d;
  logic               wr, rd;

  assign full  = (count_q == (LOG2+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // a push on a full FIFO is only accepted when the head leaves in the same cycle
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr, rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ps2_keyevent_fifo.sv
// PS/2 keyboard receiver: debounced frame capture, E0/F0 prefix decoding, event FIFO.
module ps2_keyevent_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS   = 9,
  parameter int unsigned DEBOUNCE_CYCLES = 511,
  parameter int unsigned IDLE_BITS       = 12,
  parameter int unsigned IDLE_CYCLES     = 4095,
  parameter int unsigned FIFO_LOG2       = 3,
  parameter int unsigned REPORT_BREAK    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [7:0]         ev_code,
  output logic               ev_extended,
  output logic               ev_break,
  output logic [FIFO_LOG2:0] fifo_count,
  output logic               overflow,
  output logic               frame_error,
  output logic [7:0]         err_count,
  input  logic               clear_errors
);

  logic [1:0]               clk_sync_q, data_sync_q;
  logic                     clk_s, data_s;
  logic [DEBOUNCE_BITS-1:0] lo_cnt_q;
  logic [IDLE_BITS-1:0]     hi_cnt_q;
  logic                     sample, timeout;
  rx_state_e                state_q, state_d;
  logic [3:0]               bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]    frame_q, frame_d;
  logic                     done_q, done_d;
  logic                     ext_q, ext_d, brk_q, brk_d;
  logic                     overflow_q, overflow_d;
  logic [7:0]               err_q, err_d;
  logic [7:0]               code;
  logic                     ok, push, pop, fifo_full, fifo_empty, new_ovf;
  ps2_event_t               push_ev, head_ev;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  // counters saturate so each phase yields at most one sample/timeout
  always_ff @(posedge clk) begin
    if (reset || clk_s) lo_cnt_q <= '0;
    else if (lo_cnt_q != DEBOUNCE_BITS'(DEBOUNCE_CYCLES)) lo_cnt_q <= lo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || !clk_s || state_q == RX_IDLE) hi_cnt_q <= '0;
    else if (hi_cnt_q != IDLE_BITS'(IDLE_CYCLES)) hi_cnt_q <= hi_cnt_q + 1'b1;
  end

  assign sample  = !clk_s && (lo_cnt_q == DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1));
  assign timeout = (state_q == RX_RECV) && clk_s && (hi_cnt_q == IDLE_BITS'(IDLE_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (sample) begin
          frame_d[0] = data_s;
          bit_cnt_d  = 4'd1;
          state_d    = RX_RECV;
        end
      end
      RX_RECV: begin
        if (timeout) begin
          bit_cnt_d = '0;
          state_d   = RX_IDLE;
        end else if (sample) begin
          frame_d[bit_cnt_q] = data_s;
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = RX_IDLE;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
    end
  end

  // frame_q still holds the completed frame during the cycle after the stop sample
  assign ok          = frame_ok(frame_q);
  assign code        = frame_q[8:1];
  assign frame_error = done_q && !ok;
  assign push        = done_q && ok && code != CODE_EXT && code != CODE_BRK &&
                       (REPORT_BREAK != 0 || !brk_q);
  assign push_ev     = '{ext: ext_q, brk: brk_q, code: code};
  assign pop         = ev_valid && ev_ready;
  assign new_ovf     = push && fifo_full && !pop;

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    if (done_q) begin
      if (ok && code == CODE_EXT) ext_d = 1'b1;
      else if (ok && code == CODE_BRK) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (new_ovf) overflow_d = 1'b1;
    else if (clear_errors) overflow_d = 1'b0;
    if (clear_errors) err_d = frame_error ? 8'd1 : 8'd0;
    else if (frame_error && err_q != 8'hFF) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= '0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
    end
  end

  ps2_event_fifo #(
    .LOG2(FIFO_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_ev),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (head_ev)
  );

  assign ev_valid    = !fifo_empty;
  assign ev_code     = head_ev.code;
  assign ev_extended = head_ev.ext;
  assign ev_break    = head_ev.brk;
  assign overflow    = overflow_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_ps2_keyevent_fifo.sv
// Scoreboard bench: a key-event model fills expected queues, monitors pop and compare.
module tb_ps2_keyevent_fifo;

  localparam int DB   = 20;
  localparam int IDLE = 100;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       ev_ready = 1'b0, clear_errors = 1'b0;
  logic       ev_valid, ev_extended, ev_break, overflow, frame_error;
  logic [7:0] ev_code, err_count;
  logic [3:0] fifo_count;
  logic       nb_valid, nb_ext, nb_brk, nb_ovf, nb_fe;
  logic [7:0] nb_code, nb_err;
  logic [3:0] nb_count;

  always #5 clk = ~clk;

  ps2_keyevent_fifo #(
    .DEBOUNCE_BITS(5), .DEBOUNCE_CYCLES(DB), .IDLE_BITS(7), .IDLE_CYCLES(IDLE),
    .FIFO_LOG2(3), .REPORT_BREAK(1)
  ) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_extended(ev_extended), .ev_break(ev_break), .fifo_count(fifo_count),
    .overflow(overflow), .frame_error(frame_error), .err_count(err_count),
    .clear_errors(clear_errors)
  );

  ps2_keyevent_fifo #(
    .DEBOUNCE_BITS(5), .DEBOUNCE_CYCLES(DB), .IDLE_BITS(7), .IDLE_CYCLES(IDLE),
    .FIFO_LOG2(3), .REPORT_BREAK(0)
  ) dut_nb (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_valid(nb_valid), .ev_ready(1'b1), .ev_code(nb_code),
    .ev_extended(nb_ext), .ev_break(nb_brk), .fifo_count(nb_count),
    .overflow(nb_ovf), .frame_error(nb_fe), .err_count(nb_err),
    .clear_errors(clear_errors)
  );

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ev_t;

  ev_t sb[$];
  ev_t nb_sb[$];
  int  total = 0, bad = 0;
  int  m_err = 0;
  bit  m_ext = 0, m_brk = 0, m_ovf = 0;
  bit  rand_ready = 0;
  int  fe_pulses = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Reference: prefix bytes arm flags, any other good byte becomes an event.
  function automatic void model(input logic [7:0] b, input bit badp);
    ev_t e;
    if (badp) begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      e = '{ext: m_ext, brk: m_brk, code: b};
      if (sb.size() < 8) sb.push_back(e);
      else m_ovf = 1;
      if (!m_brk) nb_sb.push_back(e);
      m_ext = 0;
      m_brk = 0;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      idle(HALF);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit badp);
    return {1'b1, (~^b) ^ badp, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit badp);
    send_bits(mkframe(b, badp), 11);
    idle(HALF + 10);
  endtask

  task automatic frame(input logic [7:0] b, input bit badp);
    model(b, badp);
    send_frame(b, badp);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || nb_sb.size() != 0) && k < 500) begin
      idle(1);
      k++;
    end
    check("drain_left", 32'(sb.size() + nb_sb.size()), 0);
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    idle(1);
    clear_errors = 1'b0;
    idle(1);
  endtask

  // main-DUT monitor: pops on handshake, head must hold while stalled
  logic        prev_hold = 1'b0;
  logic [10:0] prev_head;
  always @(negedge clk) begin
    ev_t e;
    if (reset) prev_hold <= 1'b0;
    else begin
      if (frame_error) fe_pulses++;
      if (prev_hold)
        check("head_hold", 32'({ev_valid, ev_extended, ev_break, ev_code}), 32'({1'b1, prev_head[9:0]}));
      if (ev_valid && ev_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: actual=%0h required=none", {ev_extended, ev_break, ev_code});
        end else begin
          e = sb.pop_front();
          check("event", 32'({ev_extended, ev_break, ev_code}), 32'(e));
        end
      end
      prev_hold <= ev_valid && !ev_ready;
      prev_head <= {1'b0, ev_extended, ev_break, ev_code};
    end
  end

  // REPORT_BREAK=0 instance, always ready
  always @(negedge clk) begin
    ev_t e;
    if (!reset && nb_valid) begin
      if (nb_sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL nb_unexpected_event: actual=%0h required=none", {nb_ext, nb_brk, nb_code});
      end else begin
        e = nb_sb.pop_front();
        check("nb_event", 32'({nb_ext, nb_brk, nb_code}), 32'(e));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) ev_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int fe0, k;
    logic [7:0] b;
    bit badp;

    idle(4);
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    reset = 1'b0;
    idle(4);
    check("rst_head", 32'({ev_extended, ev_break, ev_code}), 0);
    check("rst_err", 32'({overflow, frame_error, err_count}), 0);

    // single make code
    frame(8'h1C, 0);
    check("one_count", 32'(fifo_count), 1);
    check("one_head", 32'({ev_valid, ev_code}), 32'h11C);
    ev_ready = 1'b1;
    idle(3);
    ev_ready = 1'b0;
    check("one_drained", 32'(fifo_count), 0);

    // extended break sequence
    frame(8'hE0, 0);
    frame(8'hF0, 0);
    frame(8'h75, 0);
    check("ebrk_count", 32'(fifo_count), 1);
    check("ebrk_head", 32'({ev_extended, ev_break, ev_code}), 32'h375);
    ev_ready = 1'b1;
    idle(3);
    ev_ready = 1'b0;

    // parity error, then clear
    fe0 = fe_pulses;
    frame(8'h1C, 1);
    check("perr_pulses", 32'(fe_pulses - fe0), 1);
    check("perr_count", 32'(err_count), 32'(m_err));
    check("perr_fifo", 32'(fifo_count), 0);
    pulse_clear();
    m_err = 0;
    check("clr_err", 32'(err_count), 0);

    // error arriving in the same cycle as clear_errors wins
    frame(8'h1C, 1);
    model(8'h1C, 1);
    fork
      send_frame(8'h1C, 1);
    join_none
    k = 0;
    while (!frame_error && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("clr_race_seen", 32'(frame_error), 1);
    clear_errors = 1'b1;
    @(posedge clk);
    #1;
    clear_errors = 1'b0;
    wait fork;
    m_err = 1;
    check("clr_race_err", 32'(err_count), 1);
    pulse_clear();
    m_err = 0;

    // overflow: nine events into an eight-deep FIFO
    for (int i = 0; i < 9; i++) frame(8'h10 + 8'(i), 0);
    check("ovf_count", 32'(fifo_count), 8);
    check("ovf_flag", 32'(overflow), 32'(m_ovf));
    check("ovf_head", 32'(ev_code), 32'h10);
    ev_ready = 1'b1;
    drain();
    ev_ready = 1'b0;
    check("ovf_sticky", 32'(overflow), 1);
    pulse_clear();
    m_ovf = 0;
    check("ovf_clr", 32'(overflow), 0);

    // partial frame abandoned by idle timeout keeps the prefix flag
    frame(8'hE0, 0);
    fe0 = fe_pulses;
    send_bits(mkframe(8'h55, 0), 5);
    idle(IDLE + 30);
    check("idle_no_err", 32'(fe_pulses - fe0), 0);
    check("idle_no_ev", 32'(fifo_count), 0);
    frame(8'h29, 0);
    check("idle_next", 32'({fifo_count, ev_extended, ev_code}), 32'({4'd1, 1'b1, 8'h29}));
    ev_ready = 1'b1;
    drain();
    ev_ready = 1'b0;

    // short low glitch must not be sampled
    fe0 = fe_pulses;
    ps2_clk = 1'b0;
    idle(DB - 12);
    ps2_clk = 1'b1;
    idle(50);
    frame(8'h5A, 0);
    check("glitch_no_err", 32'(fe_pulses - fe0), 0);
    check("glitch_ev", 32'({fifo_count, ev_code}), 32'({4'd1, 8'h5A}));
    ev_ready = 1'b1;
    drain();
    ev_ready = 1'b0;

    // reset in the middle of a frame
    frame(8'hE0, 0);
    send_bits(mkframe(8'h66, 0), 4);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    m_ext = 0;
    m_brk = 0;
    idle(5);
    frame(8'h3C, 0);
    check("midrst_ev", 32'({fifo_count, ev_extended, ev_break, ev_code}), 32'({4'd1, 2'b00, 8'h3C}));
    ev_ready = 1'b1;
    drain();

    // randomized traffic with a randomly stalling consumer
    rand_ready = 1;
    for (int i = 0; i < 25; i++) begin
      k = int'($urandom_range(0, 9));
      b = (k < 2) ? 8'hE0 : (k < 4) ? 8'hF0 : 8'($urandom);
      badp = ($urandom_range(0, 9) == 0);
      frame(b, badp);
    end
    rand_ready = 0;
    ev_ready = 1'b1;
    drain();
    check("rand_err", 32'(err_count), 32'(m_err));
    check("rand_ovf", 32'(overflow), 32'(m_ovf));
    check("rand_empty", 32'({ev_valid, fifo_count}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
